cover_toggle_collector: RTL
===========================

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 5: number of toggle points, legal 1..64.
REQ-002 SHALL have parameter COVER_INDEX, default 0: global index of point 0.
REQ-003 SHALL have parameter COVER_TOTAL, default 10906: global point count; elaboration error if COVER_INDEX+WIDTH > COVER_TOTAL.
REQ-004 SHALL have parameter MODE, default FIRST_HIT: FIRST_HIT reports each point once; EVERY_HIT reports every hit.
REQ-005 SHALL have port clock, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low (0 = in reset).
REQ-007 SHALL have port enable, input, 1: samples valid only when 1.
REQ-008 SHALL have port clear, input, 1: synchronous pulse clearing coverage state.
REQ-009 SHALL have port valid, input, WIDTH: per-point hit strobes.
REQ-010 SHALL have port rpt_valid, output, 1: report beat available.
REQ-011 SHALL have port rpt_ready, input, 1: consumer accepts beat.
REQ-012 SHALL have port rpt_index, output, 64: global index (COVER_INDEX + bit).
REQ-013 SHALL have port covered, output, WIDTH: sticky hit bitmap.
REQ-014 SHALL have port covered_count, output, clog2(WIDTH+1): popcount of covered.
REQ-015 SHALL have port all_covered, output, 1: covered is all ones.
REQ-016 SHALL have port drop_count, output, 16: saturating count of hits lost in EVERY_HIT mode.

Function
REQ-017 SHALL define hit = valid & {WIDTH{enable}}, sampled at each rising edge.
REQ-018 SHALL set covered[i] on the edge following hit[i]=1; bits stay set until clear or reset.
REQ-019 SHALL keep a pending bitmap: FIRST_HIT sets pending[i] when hit[i] & ~covered[i]; EVERY_HIT sets pending[i] on every hit[i].
REQ-020 SHALL, in EVERY_HIT mode, increment drop_count by the number of hit bits whose pending bit is already set and not being cleared that edge, saturating at 0xFFFF.
REQ-021 SHALL hold one output register; it loads when empty or when rpt_valid & rpt_ready, taking the lowest-numbered set pending bit, clearing that bit the same edge.
REQ-022 SHALL hold rpt_valid and rpt_index stable while rpt_valid & ~rpt_ready.
REQ-023 SHALL give latency: hit at edge t -> rpt_valid high after edge t+1, with rpt_ready held 1 and no lower pending bits.
REQ-024 SHALL sustain one report per cycle under continuous rpt_ready.
REQ-025 SHALL, on a pending bit newly set the same edge it is selected, keep it set (set wins over select only for new hits).
REQ-026 SHALL, on clear, zero covered, pending, covered_count, drop_count; hits in the clear cycle are discarded; a beat already in the output register is kept until accepted.
REQ-027 SHALL update covered_count and all_covered combinationally from covered.
REQ-028 SHALL never report an index twice in FIRST_HIT mode between clears.

Reset
REQ-029 SHALL, while reset=0, force covered=0, pending=0, rpt_valid=0, rpt_index=0, drop_count=0, covered_count=0, all_covered=0 (WIDTH>0).
REQ-030 SHALL abandon any undelivered beat on reset; first report possible two edges after reset release.

Structure
REQ-031 SHALL place COVER_INDEX_W=64, the MODE enum (FIRST_HIT, EVERY_HIT) and DROP_W=16 in shared package cover_pkg.
REQ-032 SHALL instantiate one sub-module cover_lowest_set: WIDTH-bit lowest-set-bit priority encoder giving found flag and bit position.
REQ-033 SHALL contain no DPI calls; reporting is purely via the rpt handshake.

Verification
REQ-034 SHALL check: WIDTH=5, COVER_INDEX=100, FIRST_HIT, valid=5'b10101 one cycle, rpt_ready=1 -> rpt_index 100,102,104 on consecutive cycles, covered_count=3.
REQ-035 SHALL check: rpt_ready=0 for 4 cycles with a beat pending -> rpt_index stable, no loss, all delivered after rpt_ready=1.
REQ-036 SHALL check: FIRST_HIT, valid[2] pulsed 3 times -> exactly one beat 102; after clear, another pulse -> one more beat 102.
REQ-037 SHALL check: EVERY_HIT, valid=5'b00001 for 4 cycles with rpt_ready=0 -> 1 beat held, 1 pending, drop_count=2.
REQ-038 SHALL check: valid=5'b11111 until all_covered=1, then reset=0 mid-drain -> all outputs zero immediately, no beat after release without new hits.

Source files
------------

// File: rtl/cover_pkg.sv
// Shared types and widths for the toggle-coverage collector.
package cover_pkg;

    localparam int COVER_INDEX_W = 64;
    localparam int DROP_W        = 16;

    typedef enum logic {
        FIRST_HIT = 1'b0,
        EVERY_HIT = 1'b1
    } cover_mode_e;

    // Width needed to hold a bit position of a WIDTH-bit vector (at least 1).
    function automatic int pos_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/cover_lowest_set.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
module cover_lowest_set
    import cover_pkg::*;
#(
    parameter  int WIDTH = 5,
    localparam int POS_W = pos_width(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    output logic             found,
    output logic [POS_W-1:0] pos
);

    always_comb begin
        found = 1'b0;
        pos   = '0;
        // Scanning downward lets the lowest set bit overwrite any higher one.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) begin
                found = 1'b1;
                pos   = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Collects per-point toggle hits into a sticky bitmap and streams the global
// index of each reported point through a single-entry valid/ready register.
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter  int              WIDTH       = 5,
    parameter  longint unsigned COVER_INDEX = 0,
    parameter  longint unsigned COVER_TOTAL = 10906,
    parameter  cover_mode_e     MODE        = FIRST_HIT,
    localparam int              COUNT_W     = $clog2(WIDTH + 1),
    localparam int              POS_W       = pos_width(WIDTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         valid,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [COVER_INDEX_W-1:0] rpt_index,
    output logic [WIDTH-1:0]         covered,
    output logic [COUNT_W-1:0]       covered_count,
    output logic                     all_covered,
    output logic [DROP_W-1:0]        drop_count
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("cover_toggle_collector: WIDTH must be in 1..64");
    end

    if (COVER_INDEX + 64'(WIDTH) > COVER_TOTAL) begin : g_bad_range
        $error("cover_toggle_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0]  hit;
    logic [WIDTH-1:0]  pending;
    logic [WIDTH-1:0]  pending_next;
    logic [WIDTH-1:0]  new_set;
    logic [WIDTH-1:0]  sel_mask;
    logic [WIDTH-1:0]  covered_next;
    logic              found;
    logic [POS_W-1:0]  sel_pos;
    logic              load_en;
    logic              take;
    logic [6:0]        drop_inc;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_next;

    cover_lowest_set #(
        .WIDTH (WIDTH)
    ) u_lowest (
        .bits  (pending),
        .found (found),
        .pos   (sel_pos)
    );

    always_comb begin
        hit      = valid & {WIDTH{enable}};
        load_en  = ~rpt_valid | rpt_ready;
        take     = found & load_en & ~clear;
        sel_mask = '0;
        if (take) begin
            sel_mask[sel_pos] = 1'b1;
        end

        new_set = (MODE == EVERY_HIT) ? hit : (hit & ~covered);

        // A re-hit only counts as lost if its pending bit survives this edge.
        drop_inc = '0;
        if (MODE == EVERY_HIT) begin
            for (int i = 0; i < WIDTH; i++) begin
                drop_inc = drop_inc + 7'(hit[i] & pending[i] & ~sel_mask[i]);
            end
        end
        drop_sum  = {1'b0, drop_count} + (DROP_W + 1)'(drop_inc);
        drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

        if (clear) begin
            covered_next = '0;
            pending_next = '0;
            drop_next    = '0;
        end else begin
            covered_next = covered | hit;
            pending_next = (pending & ~sel_mask) | new_set;
        end
    end

    always_comb begin
        covered_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            covered_count = covered_count + COUNT_W'(covered[i]);
        end
        all_covered = &covered;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            covered    <= '0;
            pending    <= '0;
            drop_count <= '0;
            rpt_valid  <= 1'b0;
            rpt_index  <= '0;
        end else begin
            covered    <= covered_next;
            pending    <= pending_next;
            drop_count <= drop_next;
            // A beat already held survives clear; it is only retired by acceptance.
            if (load_en) begin
                rpt_valid <= take;
                if (take) begin
                    rpt_index <= COVER_INDEX_W'(COVER_INDEX) + COVER_INDEX_W'(sel_pos);
                end
            end
        end
    end

endmodule
